// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined signed MAC with framed accumulation, rounding rescale and saturation
module myproject_mac_pipe #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 15,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 40,
  parameter int SHIFT      = 10,
  parameter int dout_WIDTH = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH+2-dout_WIDTH){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH+2-dout_WIDTH){1'b1}}, {(dout_WIDTH-1){1'b0}}};
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] p [NUM_STAGE];
  logic [NUM_STAGE-1:0] pv, pf, pl;
  logic signed [ACC_WIDTH-1:0] acc;
  logic acc_last;
  logic signed [ACC_WIDTH:0] rnd, r;
  logic hi, lo;
  logic signed [dout_WIDTH-1:0] sat;
  assign prod = PW'(din0) * PW'(din1);
  always_comb begin
    rnd = {acc[ACC_WIDTH-1], acc} + HALF;
    r   = rnd >>> SHIFT;
    hi  = r > MAXV;
    lo  = r < MINV;
    sat = hi ? MAXV[dout_WIDTH-1:0] : lo ? MINV[dout_WIDTH-1:0] : r[dout_WIDTH-1:0];
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pv        <= '0;
      pf        <= '0;
      pl        <= '0;
      acc       <= '0;
      acc_last  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_ovf  <= 1'b0;
    end else if (ce) begin
      p[0]  <= prod;
      pv[0] <= in_valid;
      pf[0] <= in_first;
      pl[0] <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        p[i]  <= p[i-1];
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pl[i] <= pl[i-1];
      end
      if (pv[NUM_STAGE-1])
        acc <= pf[NUM_STAGE-1] ? ACC_WIDTH'(p[NUM_STAGE-1]) : acc + ACC_WIDTH'(p[NUM_STAGE-1]);
      acc_last  <= pv[NUM_STAGE-1] & pl[NUM_STAGE-1];
      out_valid <= acc_last;
      // the output stage reads the completed group while the next group may already overwrite acc
      if (acc_last) begin
        dout     <= sat;
        dout_ovf <= hi | lo;
      end
    end
  end
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: directed vectors with a queue scoreboard checking value and enabled-cycle latency
module tb_myproject_mac_pipe;
  logic ap_clk = 1'b0, ap_rst = 1'b1, ce = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic signed [15:0] din0 = '0;
  logic signed [14:0] din1 = '0;
  logic out_valid, dout_ovf;
  logic signed [15:0] dout;
  typedef struct {int d; int o; int due;} exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, en_cnt = 0;
  logic en_edge = 1'b0;
  int pd = 0, po = 0, pv = 0;
  myproject_mac_pipe dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .dout_ovf(dout_ovf)
  );
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) begin
    en_edge <= ce;
    if (ce) en_cnt <= en_cnt + 1;
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge ap_clk) begin
    if (!en_edge) begin
      chk("hold_valid", int'(out_valid), pv);
      chk("hold_dout", int'(dout), pd);
      chk("hold_ovf", int'(dout_ovf), po);
    end else if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", int'(dout), e.d);
        chk("ovf", int'(dout_ovf), e.o);
        chk("latency", en_cnt, e.due);
      end
    end
    pv = int'(out_valid);
    pd = int'(dout);
    po = int'(dout_ovf);
  end
  task automatic push(input int d, input int o);
    exp_t e;
    e.d = d;
    e.o = o;
    e.due = en_cnt + 4;
    q.push_back(e);
  endtask
  task automatic beat(input logic v, input logic f, input logic l, input int a, input int b);
    ce = 1'b1;
    in_valid = v;
    in_first = f;
    in_last = l;
    din0 = 16'(a);
    din1 = 15'(b);
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic hold();
    ce = 1'b0;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last = 1'b1;
    din0 = 16'sh7fff;
    din1 = 15'sh3fff;
    @(posedge ap_clk);
    #1 ce = 1'b1;
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, 0);
  endtask
  task automatic rst_check();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(dout_ovf), 0);
  endtask
  initial begin
    idle(2);
    rst_check();
    ap_rst = 1'b0;
    idle(2);
    push(3, 0);
    beat(1, 1, 1, 1024, 3);
    idle(5);
    beat(1, 1, 0, -512, 1);
    beat(1, 0, 0, -512, 1);
    beat(1, 0, 0, -512, 1);
    push(-2, 0);
    beat(1, 0, 1, -512, 1);
    push(2, 0);
    beat(1, 1, 1, 2048, 1);
    idle(5);
    push(2, 0);
    beat(1, 1, 1, 1536, 1);
    push(-1, 0);
    beat(1, 1, 1, -1536, 1);
    idle(5);
    push(32767, 1);
    beat(1, 1, 1, 32767, 16383);
    push(-32768, 1);
    beat(1, 1, 1, -32768, 16383);
    idle(5);
    beat(1, 1, 0, -512, 1);
    beat(0, 0, 0, 0, 0);
    hold();
    beat(1, 0, 0, -512, 1);
    beat(1, 0, 0, -512, 1);
    push(-2, 0);
    beat(1, 0, 1, -512, 1);
    hold();
    hold();
    push(2, 0);
    beat(1, 1, 1, 2048, 1);
    idle(6);
    beat(1, 1, 0, 100, 100);
    beat(1, 0, 0, 100, 100);
    ap_rst = 1'b1;
    beat(1, 0, 0, 100, 100);
    rst_check();
    ap_rst = 1'b0;
    idle(6);
    push(0, 0);
    beat(1, 1, 1, 5, 7);
    idle(6);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
